// File: rtl/instruction_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Each buffer entry holds a fetch PC, its instruction word and a filled flag.
package instruction_prefetch_queue_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 64;
  localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic               filled;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_prefetch_queue_if.sv
// Bus bundle between the prefetch queue, instruction memory, the MEM-stage redirect and IF/ID.
// Handshake: a request transfers on any cycle where imem_req_valid && imem_req_ready; once raised,
// imem_req_valid and imem_req_addr hold until that transfer unless a redirect intervenes. Responses
// (imem_rsp_valid) have no backpressure and arrive strictly in request order; out_valid has no ready,
// the consumer holds it with stall.
interface instruction_prefetch_queue_if;
  import instruction_prefetch_queue_pkg::*;

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               stall;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic [ADDR_W-1:0]  out_pc_plus4;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, out_pc_plus4,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, stall
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, out_pc_plus4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, stall
  );

endinterface

// File: rtl/instruction_prefetch_queue_fetch_entry_buffer.sv
// DEPTH-entry circular buffer with independent alloc (issue), fill (response) and pop (consume) pointers.
// Pointers carry one extra wrap bit so occupancy counts fall out of plain subtraction.
module instruction_prefetch_queue_fetch_entry_buffer
  import instruction_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               alloc_i,
  input  logic [ADDR_W-1:0]  alloc_pc_i,
  input  logic               fill_i,
  input  logic [INSTR_W-1:0] fill_data_i,
  input  logic               pop_i,
  output fetch_entry_t       head_o,
  output logic [CW-1:0]      alloc_cnt_o,
  output logic [CW-1:0]      unfilled_cnt_o
);

  fetch_entry_t      entry_q [DEPTH];
  fetch_entry_t      entry_d [DEPTH];
  logic [CW-1:0]     wr_q, wr_d, fill_q, fill_d, rd_q, rd_d;

  // The three pointers never address the same slot in one cycle while
  // their operations are enabled, so the updates below cannot collide.
  always_comb begin
    entry_d = entry_q;
    wr_d    = wr_q;
    fill_d  = fill_q;
    rd_d    = rd_q;
    if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) entry_d[i].filled = 1'b0;
      wr_d   = '0;
      fill_d = '0;
      rd_d   = '0;
    end else begin
      if (alloc_i) begin
        entry_d[wr_q[PW-1:0]].pc     = alloc_pc_i;
        entry_d[wr_q[PW-1:0]].filled = 1'b0;
        wr_d = wr_q + CW'(1);
      end
      if (fill_i) begin
        entry_d[fill_q[PW-1:0]].instr  = fill_data_i;
        entry_d[fill_q[PW-1:0]].filled = 1'b1;
        fill_d = fill_q + CW'(1);
      end
      // Clearing filled on pop keeps a stale slot from looking valid once the queue drains.
      if (pop_i) begin
        entry_d[rd_q[PW-1:0]].filled = 1'b0;
        rd_d = rd_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q <= '{default: '0};
      wr_q    <= '0;
      fill_q  <= '0;
      rd_q    <= '0;
    end else begin
      entry_q <= entry_d;
      wr_q    <= wr_d;
      fill_q  <= fill_d;
      rd_q    <= rd_d;
    end
  end

  assign head_o         = entry_q[rd_q[PW-1:0]];
  assign alloc_cnt_o    = wr_q - rd_q;
  assign unfilled_cnt_o = wr_q - fill_q;

endmodule

// File: rtl/instruction_prefetch_queue.sv
// Sequential-PC instruction prefetcher: issues fetches, buffers in-order responses and feeds IF/ID.
// A redirect flushes the buffer; responses still owed for flushed requests are counted and discarded.
module instruction_prefetch_queue
  import instruction_prefetch_queue_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int               CW       = $clog2(DEPTH) + 1
) (
  input logic                   clock,
  input logic                   reset,
  instruction_prefetch_queue_if.master bus
);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic              run_q;
  logic [CW-1:0]     alloc_cnt, unfilled_cnt;
  fetch_entry_t      head;
  logic              fire, rsp_live, rsp_drop, rsp_taken, fill, pop, out_valid;

  // run_q holds off requests for the first cycle after reset release.
  assign bus.imem_req_valid = run_q && !bus.redirect_valid && (alloc_cnt < CW'(DEPTH));
  assign bus.imem_req_addr  = fetch_pc_q;
  assign fire = bus.imem_req_valid && bus.imem_req_ready;

  // A response with nothing owed (protocol error) is neither dropped nor filled.
  assign rsp_drop  = bus.imem_rsp_valid && (drop_cnt_q != '0);
  assign rsp_live  = bus.imem_rsp_valid && (drop_cnt_q == '0) && (unfilled_cnt != '0);
  assign rsp_taken = rsp_drop || rsp_live;
  assign fill      = rsp_live && !bus.redirect_valid;

  assign out_valid = head.filled;
  assign pop       = out_valid && !bus.stall && !bus.redirect_valid;

  assign bus.out_valid    = out_valid;
  assign bus.out_instr    = out_valid ? head.instr : '0;
  assign bus.out_pc       = out_valid ? head.pc : '0;
  assign bus.out_pc_plus4 = out_valid ? head.pc + PC_STEP : '0;

  instruction_prefetch_queue_fetch_entry_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk_i          (clock),
    .rst_ni         (reset),
    .clear_i        (bus.redirect_valid),
    .alloc_i        (fire),
    .alloc_pc_i     (fetch_pc_q),
    .fill_i         (fill),
    .fill_data_i    (bus.imem_rsp_data),
    .pop_i          (pop),
    .head_o         (head),
    .alloc_cnt_o    (alloc_cnt),
    .unfilled_cnt_o (unfilled_cnt)
  );

  // On redirect every unfilled entry becomes a response to discard, less any response landing now.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
      drop_cnt_d = drop_cnt_q + unfilled_cnt - CW'(rsp_taken);
    end else begin
      if (fire)     fetch_pc_d = fetch_pc_q + PC_STEP;
      if (rsp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
      run_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
      run_q      <= 1'b1;
    end
  end

  a_rsp_expected: assert property (@(posedge clock) disable iff (!reset)
    bus.imem_rsp_valid |-> (drop_cnt_q != '0) || (unfilled_cnt != '0));

  a_drop_bounded: assert property (@(posedge clock) disable iff (!reset)
    drop_cnt_q <= CW'(DEPTH));

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Bench for instruction_prefetch_queue: directed scenarios then random traffic against a queue-level model.
module tb_instruction_prefetch_queue;
  import instruction_prefetch_queue_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    bit          filled;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  instruction_prefetch_queue_if bus();

  instruction_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // model: queued entries in order, in-flight requests (1 = still owned by a queue entry)
  ent_t        exp_q[$];
  bit          infl_q[$];
  logic [63:0] m_pc;
  bit          m_run;

  // memory: in-order response schedule
  logic [63:0] mem_addr_q[$];
  longint      mem_due_q[$];
  longint      last_due;

  int          rdy_mode, stall_mode, lat_mode;
  bit          rand_redir, redir_req;
  logic [63:0] redir_addr;

  logic [63:0] fire_log[$], pop_pc_log[$], pop_p4_log[$];
  logic [31:0] pop_instr_log[$];
  longint      pop_cyc_log[$];

  longint cyc = 0;
  int     errs = 0;
  int     checks = 0;

  function automatic logic [31:0] instr_of(logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_logs();
    fire_log.delete(); pop_pc_log.delete(); pop_p4_log.delete();
    pop_instr_log.delete(); pop_cyc_log.delete();
  endtask

  function automatic logic [63:0] rand_target();
    logic [63:0] t;
    if ($urandom_range(0, 3) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 + {60'd0, 2'($urandom_range(0, 3)), 2'b00};
    else t = {32'($urandom), 32'($urandom)} & ~64'h3;
    return t;
  endfunction

  // ---- driver ----
  task automatic drive();
    if (mem_due_q.size() > 0 && mem_due_q[0] == cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = instr_of(mem_addr_q[0]);
      void'(mem_due_q.pop_front());
      void'(mem_addr_q.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    case (rdy_mode)
      1: bus.imem_req_ready = 1'b1;
      2: bus.imem_req_ready = 1'b0;
      default: bus.imem_req_ready = ($urandom_range(0, 3) != 0);
    endcase
    case (stall_mode)
      1: bus.stall = 1'b1;
      2: bus.stall = 1'b0;
      default: bus.stall = ($urandom_range(0, 9) < 3);
    endcase
    if (redir_req) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = redir_addr;
      redir_req = 1'b0;
    end else if (rand_redir && $urandom_range(0, 24) == 0) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = rand_target();
    end else begin
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = {32'($urandom), 32'($urandom)};
    end
  endtask

  // ---- compare against model, then advance model across the coming edge ----
  task automatic check_update();
    bit   e_ov, e_rv, fire, pop, live;
    int   fidx;
    int   lat;
    ent_t e;
    e_ov = (exp_q.size() > 0) && exp_q[0].filled;
    e_rv = m_run && !bus.redirect_valid && (exp_q.size() < DEPTH);
    chk("out_valid", {63'd0, bus.out_valid}, {63'd0, e_ov});
    chk("req_valid", {63'd0, bus.imem_req_valid}, {63'd0, e_rv});
    if (e_rv) chk("req_addr", bus.imem_req_addr, m_pc);
    if (e_ov) begin
      chk("out_pc", bus.out_pc, exp_q[0].pc);
      chk("out_instr", {32'd0, bus.out_instr}, {32'd0, exp_q[0].instr});
      chk("out_pc_plus4", bus.out_pc_plus4, exp_q[0].pc + 64'd4);
    end
    fire = e_rv && bus.imem_req_ready;
    pop  = e_ov && !bus.stall && !bus.redirect_valid;
    if (bus.imem_rsp_valid && infl_q.size() > 0) begin
      live = infl_q.pop_front();
      if (live && !bus.redirect_valid) begin
        fidx = -1;
        for (int i = 0; i < exp_q.size(); i++) if (!exp_q[i].filled) begin fidx = i; break; end
        if (fidx >= 0) begin
          e = exp_q[fidx]; e.filled = 1'b1; e.instr = bus.imem_rsp_data; exp_q[fidx] = e;
        end
      end
    end
    if (bus.redirect_valid) begin
      exp_q.delete();
      for (int i = 0; i < infl_q.size(); i++) infl_q[i] = 1'b0;
      m_pc = bus.redirect_pc;
    end else begin
      if (pop) begin
        pop_pc_log.push_back(exp_q[0].pc);
        pop_p4_log.push_back(exp_q[0].pc + 64'd4);
        pop_instr_log.push_back(exp_q[0].instr);
        pop_cyc_log.push_back(cyc);
        void'(exp_q.pop_front());
      end
      if (fire) begin
        e.pc = m_pc; e.instr = '0; e.filled = 1'b0;
        exp_q.push_back(e);
        infl_q.push_back(1'b1);
        fire_log.push_back(m_pc);
        lat = (lat_mode == 0) ? $urandom_range(1, 4) : lat_mode;
        last_due = (last_due + 1 > cyc + lat) ? last_due + 1 : cyc + lat;
        mem_addr_q.push_back(m_pc);
        mem_due_q.push_back(last_due);
        m_pc = m_pc + 64'd4;
      end
    end
    m_run = 1'b1;
    cyc++;
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    check_update();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
    chk("rst_req_addr", bus.imem_req_addr, 64'h0);
    chk("rst_out_pc", bus.out_pc, 64'h0);
    chk("rst_out_instr", {32'd0, bus.out_instr}, 64'h0);
    chk("rst_out_pc_plus4", bus.out_pc_plus4, 64'h0);
    exp_q.delete(); infl_q.delete(); mem_addr_q.delete(); mem_due_q.delete();
    m_pc = 64'h0; m_run = 1'b0; last_due = cyc; redir_req = 1'b0;
    clear_logs();
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0; bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_modes(int r, int s, int l, bit rr);
    rdy_mode = r; stall_mode = s; lat_mode = l; rand_redir = rr;
  endtask

  task automatic count_stale(output int n);
    n = 0;
    for (int i = 0; i < infl_q.size(); i++) if (!infl_q[i]) n++;
  endtask

  initial begin
    int stale;
    set_modes(1, 2, 1, 1'b0);
    apply_reset();

    // 1: sequential fetch with 1-cycle memory
    repeat (6) cycle();
    chk("t1_fire0", fire_log[0], 64'h0);
    chk("t1_fire1", fire_log[1], 64'h4);
    chk("t1_fire2", fire_log[2], 64'h8);
    chk("t1_pop0", pop_pc_log[0], 64'h0);
    chk("t1_pop1", pop_pc_log[1], 64'h4);
    chk("t1_plus4", pop_p4_log[0], 64'h4);
    chk("t1_back_to_back", 64'(pop_cyc_log[1] - pop_cyc_log[0]), 64'd1);

    // 2: decode stall fills the queue
    apply_reset();
    set_modes(1, 1, 1, 1'b0);
    repeat (10) cycle();
    chk("t2_allocs", 64'(fire_log.size()), 64'd4);
    chk("t2_req_blocked", {63'd0, bus.imem_req_valid}, 64'd0);
    chk("t2_hold_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("t2_hold_pc", bus.out_pc, 64'h0);
    set_modes(1, 2, 1, 1'b0);
    repeat (8) cycle();
    chk("t2_drain0", pop_pc_log[0], 64'h0);
    chk("t2_drain1", pop_pc_log[1], 64'h4);
    chk("t2_drain2", pop_pc_log[2], 64'h8);
    chk("t2_drain3", pop_pc_log[3], 64'hC);

    // 3: redirect with two requests in flight
    apply_reset();
    set_modes(1, 2, 3, 1'b0);
    repeat (3) cycle();
    chk("t3_inflight", 64'(infl_q.size()), 64'd2);
    redir_req = 1'b1; redir_addr = 64'h100;
    cycle();
    count_stale(stale);
    chk("t3_drop", 64'(stale), 64'd2);
    clear_logs();
    repeat (10) cycle();
    chk("t3_first_pc", pop_pc_log[0], 64'h100);
    chk("t3_first_instr", {32'd0, pop_instr_log[0]}, 64'hC0DE_0100);

    // 4: redirect coinciding with a response and a would-be pop
    apply_reset();
    set_modes(1, 2, 2, 1'b0);
    repeat (8) cycle();
    chk("t4_setup_inflight", 64'(infl_q.size()), 64'd2);
    clear_logs();
    redir_req = 1'b1; redir_addr = 64'h200;
    cycle();
    chk("t4_no_pop", 64'(pop_pc_log.size()), 64'd0);
    count_stale(stale);
    chk("t4_drop", 64'(stale), 64'd1);
    chk("t4_empty_next", {63'd0, bus.out_valid}, 64'd0);
    repeat (8) cycle();
    chk("t4_first_pc", pop_pc_log[0], 64'h200);
    chk("t4_first_instr", {32'd0, pop_instr_log[0]}, 64'hC0DE_0200);

    // 5: memory not ready
    apply_reset();
    set_modes(1, 2, 1, 1'b0);
    repeat (3) cycle();
    set_modes(2, 2, 1, 1'b0);
    repeat (5) cycle();
    chk("t5_no_dup", 64'(fire_log.size()), 64'd2);
    chk("t5_addr", bus.imem_req_addr, 64'h8);
    chk("t5_valid", {63'd0, bus.imem_req_valid}, 64'd1);
    set_modes(1, 2, 1, 1'b0);
    cycle();
    chk("t5_fire", fire_log[2], 64'h8);

    // 6: PC wraps at the top of the address space
    redir_req = 1'b1; redir_addr = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    clear_logs();
    repeat (4) cycle();
    chk("t6_fire_top", fire_log[0], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t6_fire_wrap", fire_log[1], 64'h0);
    chk("t6_plus4_wrap", pop_p4_log[0], 64'h0);

    // 7: asynchronous reset mid-burst
    repeat (3) cycle();
    #2;
    chk("t7_pre_out_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("t7_pre_req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t7_out_valid_async", {63'd0, bus.out_valid}, 64'd0);
    chk("t7_req_valid_async", {63'd0, bus.imem_req_valid}, 64'd0);
    @(posedge clk); #1;
    apply_reset();

    // random traffic
    set_modes(0, 0, 0, 1'b1);
    repeat (3000) cycle();
    set_modes(1, 2, 0, 1'b0);
    repeat (20) cycle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
